// File: rtl/cpu_io_pkg.sv
// -----------------------------------------------------------------------------
// cpu_io_pkg
// Shared definitions for the CPU serial I/O path: default UART timing and
// queue size, the receiver and word-assembly state encodings, and a helper
// that appends one received byte to a big-endian word.
// -----------------------------------------------------------------------------
package cpu_io_pkg;

  localparam int DEF_CLKS_PER_BIT = 2604;
  localparam int DEF_QUEUE_DEPTH  = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [2:0] {
    WIDLE = 3'd0,
    WAIT  = 3'd1,
    POP0  = 3'd2,
    POP1  = 3'd3,
    POP2  = 3'd4,
    POP3  = 3'd5,
    DONE  = 3'd6
  } word_state_t;

  // The first byte popped ends up in bits [31:24], matching the send order.
  function automatic logic [31:0] shift_in_byte(input logic [31:0] word,
                                                input logic [7:0]  new_byte);
    return {word[23:0], new_byte};
  endfunction

endpackage

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 serial receiver. The line is brought into the clock domain through a
// two-flop synchronizer; a third flop gives the previous synchronized value
// for start-edge detection. Bits are sampled near their centre.
//
// Ports:
//   CLK        system clock
//   RST_N      asynchronous active-low reset
//   UART_RX    serial input, idle high
//   rx_byte    last received byte (valid while byte_valid is high)
//   byte_valid one-cycle pulse: a frame with a good stop bit arrived
//   frame_err  one-cycle pulse: a frame ended with a low stop bit
// -----------------------------------------------------------------------------
module uart_rx
  import cpu_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       UART_RX,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_r;
  logic             sync2_r;
  logic             prev_r;
  logic             fall_s;
  rx_state_t        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             byte_valid_r;
  logic             frame_err_r;

  // Synchronizer chain; reset to the idle level so reset release is not
  // mistaken for a start edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= UART_RX;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign fall_s = prev_r & ~sync2_r;

  // Receive FSM: start-bit qualification, eight LSB-first data bits, stop check.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'h00;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r     <= CNT_ZERO;
          bit_idx_r <= 3'd0;
          if (fall_s) begin
            state_r <= START;
          end
        end
        START: begin
          // Half a bit in: a line that is high again was only a glitch.
          if (cnt_r == HALF_M1) begin
            cnt_r <= CNT_ZERO;
            if (!sync2_r) begin
              state_r <= DATA;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_r == FULL_M1) begin
            cnt_r   <= CNT_ZERO;
            shift_r <= {sync2_r, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt_r == FULL_M1) begin
            cnt_r   <= CNT_ZERO;
            state_r <= IDLE;
            if (sync2_r) begin
              byte_valid_r <= 1'b1;
            end else begin
              frame_err_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign rx_byte    = shift_r;
  assign byte_valid = byte_valid_r;
  assign frame_err  = frame_err_r;

endmodule

// File: rtl/input_manager.sv
// -----------------------------------------------------------------------------
// input_manager
// Receives UART bytes into a circular byte queue and, on request, pops four
// of them as one big-endian 32-bit word. One queue slot is always left empty
// so that full (t+1 == s) and empty (t == s) are distinguishable.
//
// Ports:
//   CLK        system clock
//   RST_N      asynchronous active-low reset
//   UART_RX    serial input, idle high
//   rd_req     one-cycle pulse requesting one word (ignored while rd_busy)
//   rd_word    assembled word; holds its value until the next pop
//   rd_valid   one-cycle pulse, rd_word valid
//   rd_busy    high from an accepted rd_req until rd_valid
//   avail      bytes currently queued
//   overrun    sticky: a byte was dropped because the queue was full
//   frame_err  sticky: a frame had a low stop bit
// -----------------------------------------------------------------------------
module input_manager
  import cpu_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int QUEUE_DEPTH  = DEF_QUEUE_DEPTH,
  parameter int PTR_W        = $clog2(QUEUE_DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             UART_RX,
  input  logic             rd_req,
  output logic [31:0]      rd_word,
  output logic             rd_valid,
  output logic             rd_busy,
  output logic [PTR_W-1:0] avail,
  output logic             overrun,
  output logic             frame_err
);

  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] WORD_BYTES = PTR_W'(4);

  logic [7:0]       rx_byte_s;
  logic             byte_valid_s;
  logic             frame_err_s;

  logic [7:0]       queue_r [QUEUE_DEPTH];
  logic [PTR_W-1:0] t_r;
  logic [PTR_W-1:0] s_r;
  logic [PTR_W-1:0] t_next_s;
  logic [PTR_W-1:0] s_next_s;
  logic [PTR_W-1:0] avail_r;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic             overrun_r;
  logic             frame_err_r;

  word_state_t      word_state_r;
  logic [31:0]      rd_word_r;
  logic             rd_valid_r;
  logic             rd_busy_r;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_rx (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .UART_RX    (UART_RX),
    .rx_byte    (rx_byte_s),
    .byte_valid (byte_valid_s),
    .frame_err  (frame_err_s)
  );

  assign full_s = ((t_r + PTR_ONE) == s_r);
  assign push_s = byte_valid_s & ~full_s;

  // Every POP state consumes exactly one byte.
  always_comb begin
    pop_s = 1'b0;
    case (word_state_r)
      POP0, POP1, POP2, POP3: pop_s = 1'b1;
      default:                pop_s = 1'b0;
    endcase
  end

  // Next pointer values; push and pop in the same cycle both take effect.
  always_comb begin
    t_next_s = t_r;
    s_next_s = s_r;
    if (push_s) begin
      t_next_s = t_r + PTR_ONE;
    end else begin
      t_next_s = t_r;
    end
    if (pop_s) begin
      s_next_s = s_r + PTR_ONE;
    end else begin
      s_next_s = s_r;
    end
  end

  // Queue storage; contents need no reset because the pointers define validity.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      queue_r[t_r] <= rx_byte_s;
    end
  end

  // Pointers, registered fill level and sticky error flags.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      t_r         <= PTR_ZERO;
      s_r         <= PTR_ZERO;
      avail_r     <= PTR_ZERO;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      t_r     <= t_next_s;
      s_r     <= s_next_s;
      avail_r <= t_next_s - s_next_s;
      if (byte_valid_s && full_s) begin
        overrun_r <= 1'b1;
      end
      if (frame_err_s) begin
        frame_err_r <= 1'b1;
      end
    end
  end

  // Word FSM: wait for four bytes, pop them MSB-first, pulse rd_valid.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      word_state_r <= WIDLE;
      rd_word_r    <= 32'h0000_0000;
      rd_valid_r   <= 1'b0;
      rd_busy_r    <= 1'b0;
    end else begin
      rd_valid_r <= 1'b0;
      case (word_state_r)
        WIDLE: begin
          if (rd_req) begin
            rd_busy_r    <= 1'b1;
            word_state_r <= WAIT;
          end
        end
        WAIT: begin
          if (avail_r >= WORD_BYTES) begin
            word_state_r <= POP0;
          end
        end
        POP0: begin
          rd_word_r    <= shift_in_byte(rd_word_r, queue_r[s_r]);
          word_state_r <= POP1;
        end
        POP1: begin
          rd_word_r    <= shift_in_byte(rd_word_r, queue_r[s_r]);
          word_state_r <= POP2;
        end
        POP2: begin
          rd_word_r    <= shift_in_byte(rd_word_r, queue_r[s_r]);
          word_state_r <= POP3;
        end
        POP3: begin
          // The last byte lands together with the valid pulse in DONE.
          rd_word_r    <= shift_in_byte(rd_word_r, queue_r[s_r]);
          rd_valid_r   <= 1'b1;
          word_state_r <= DONE;
        end
        DONE: begin
          rd_busy_r    <= 1'b0;
          word_state_r <= WIDLE;
        end
        default: begin
          rd_busy_r    <= 1'b0;
          word_state_r <= WIDLE;
        end
      endcase
    end
  end

  assign rd_word   = rd_word_r;
  assign rd_valid  = rd_valid_r;
  assign rd_busy   = rd_busy_r;
  assign avail     = avail_r;
  assign overrun   = overrun_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_input_manager.sv
// -----------------------------------------------------------------------------
// tb_input_manager
// Directed bench for input_manager at 16 clocks per bit. A transaction-level
// model (byte queue, pending-frame list, read request bookkeeping) predicts
// every output each cycle; literal checks pin the headline results.
// -----------------------------------------------------------------------------
module tb_input_manager;

  localparam int CPB      = 16;
  localparam int DEPTH    = 512;
  localparam int PW       = 9;
  localparam int STOP_LEN = 12;
  // Cycles from driving a start bit to the byte showing in avail: stop bit
  // sampled mid-bit (9.5 bits = 152), two synchronizer flops, the registered
  // byte strobe and the pointer update.
  localparam int RX_LAT   = 156;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          UART_RX = 1'b1;
  logic          rd_req = 1'b0;
  logic [31:0]   rd_word;
  logic          rd_valid;
  logic          rd_busy;
  logic [PW-1:0] avail;
  logic          overrun;
  logic          frame_err;

  input_manager #(
    .CLKS_PER_BIT (CPB),
    .QUEUE_DEPTH  (DEPTH),
    .PTR_W        (PW)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .UART_RX   (UART_RX),
    .rd_req    (rd_req),
    .rd_word   (rd_word),
    .rd_valid  (rd_valid),
    .rd_busy   (rd_busy),
    .avail     (avail),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    int         due;
    logic [7:0] data;
    bit         good;
  } frame_t;

  frame_t      pend_q[$];
  logic [7:0]  mq[$];
  int          cyc = 0;
  bit          m_busy, m_wait, m_valid, m_ovr, m_ferr;
  int          m_start;
  logic [31:0] m_word;

  function automatic void model_clear();
    pend_q.delete();
    mq.delete();
    m_busy = 1'b0; m_wait = 1'b0; m_valid = 1'b0;
    m_ovr = 1'b0; m_ferr = 1'b0; m_start = 0; m_word = 32'h0;
  endfunction

  initial begin
    model_clear();
    forever begin
      bit was_busy;
      int k;
      @(posedge CLK);
      cyc++;
      if (!RST_N) begin
        model_clear();
      end else begin
        was_busy = m_busy;
        m_valid = 1'b0;
        // Frames complete; the queue keeps one slot empty.
        while (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
          if (pend_q[0].good) begin
            if (mq.size() < DEPTH - 1) mq.push_back(pend_q[0].data);
            else m_ovr = 1'b1;
          end else begin
            m_ferr = 1'b1;
          end
          void'(pend_q.pop_front());
        end
        // Four bytes leave on consecutive cycles, then the valid pulse.
        if (m_busy && !m_wait) begin
          k = cyc - m_start;
          if (k >= 2 && k <= 5) m_word = {m_word[23:0], mq.pop_front()};
          if (k == 5) m_valid = 1'b1;
          if (k == 6) m_busy = 1'b0;
        end
        if (!was_busy && rd_req) begin
          m_busy = 1'b1;
          m_wait = 1'b1;
        end
        if (m_wait && mq.size() >= 4) begin
          m_wait = 1'b0;
          m_start = cyc;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST_N) begin
        check("avail",     32'(avail),     32'(mq.size()));
        check("rd_busy",   32'(rd_busy),   32'(m_busy));
        check("rd_valid",  32'(rd_valid),  32'(m_valid));
        check("rd_word",   rd_word,        m_word);
        check("overrun",   32'(overrun),   32'(m_ovr));
        check("frame_err", 32'(frame_err), 32'(m_ferr));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  int last_start;

  task automatic send_byte(input logic [7:0] b, input bit good);
    frame_t f;
    @(posedge CLK); #1;
    f.due = cyc + RX_LAT; f.data = b; f.good = good;
    pend_q.push_back(f);
    last_start = cyc;
    UART_RX = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      step(CPB);
    end
    UART_RX = good;
    step(STOP_LEN);
    UART_RX = 1'b1;
  endtask

  task automatic do_read(input int budget, output logic [31:0] w,
                         output int req_cyc, output int v_cyc, output int busy_low);
    bit got;
    w = 32'h0; v_cyc = -1; busy_low = 0; got = 1'b0;
    @(posedge CLK); #1;
    rd_req = 1'b1; req_cyc = cyc;
    @(posedge CLK); #1;
    rd_req = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge CLK);
      if (rd_valid) begin
        got = 1'b1; v_cyc = cyc; w = rd_word;
      end else if (!rd_busy) begin
        busy_low++;
      end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL read_timeout: no rd_valid within %0d cycles", budget);
    end
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST_N = 1'b0;
    step(3);
    RST_N = 1'b1;
    step(2);
  endtask

  task automatic send4(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] w;
    int rq, vc, bl, t2_last;

    step(3);
    check("reset_rd_word",  rd_word,          32'h0);
    check("reset_flags",    {26'd0, rd_valid, rd_busy, overrun, frame_err, 2'b00}, 32'h0);
    check("reset_avail",    32'(avail),       32'h0);
    RST_N = 1'b1;
    step(2);

    // 1: four bytes then a read, six-cycle latency.
    send4(32'h12345678);
    step(3);
    do_read(50, w, rq, vc, bl);
    check("t1_word",    w,               32'h12345678);
    check("t1_latency", 32'(vc - rq),    32'd6);
    check("t1_avail",   32'(avail),      32'd0);

    // 2: request first, data later; valid five cycles after the 4th push.
    fork
      do_read(2000, w, rq, vc, bl);
      begin
        step(2);
        send4(32'hDEADBEEF);
        t2_last = last_start;
      end
    join
    check("t2_word",     w,                           32'hDEADBEEF);
    check("t2_latency",  32'(vc - (t2_last + RX_LAT)), 32'd5);
    check("t2_busy_low", 32'(bl),                     32'd0);

    // 3: overflow the queue; the oldest bytes survive.
    do_reset();
    for (int i = 0; i < 513; i++) send_byte(8'(i), 1'b1);
    step(3);
    check("t3_avail",   32'(avail),   32'd511);
    check("t3_overrun", 32'(overrun), 32'd1);
    do_read(50, w, rq, vc, bl);
    check("t3_word",    w,            32'h00010203);

    // 4: bad stop bit, then a good frame.
    do_reset();
    send_byte(8'hA5, 1'b0);
    step(20);
    check("t4_frame_err", 32'(frame_err), 32'd1);
    check("t4_avail0",    32'(avail),     32'd0);
    send_byte(8'h3C, 1'b1);
    step(3);
    check("t4_avail1",    32'(avail),     32'd1);

    // 5: short low glitch, then normal reception.
    do_reset();
    UART_RX = 1'b0;
    step(4);
    UART_RX = 1'b1;
    step(40);
    check("t5_glitch_avail", 32'(avail),     32'd0);
    check("t5_glitch_ferr",  32'(frame_err), 32'd0);
    send4(32'h55010203);
    step(3);
    do_read(50, w, rq, vc, bl);
    check("t5_word", w, 32'h55010203);

    // 6: asynchronous reset in the middle of a pop sequence.
    do_reset();
    send4(32'h11223344);
    step(3);
    rd_req = 1'b1;
    step(1);
    rd_req = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check("t6_async_word",  rd_word, 32'h0);
    check("t6_async_flags", {26'd0, rd_valid, rd_busy, overrun, frame_err, 2'b00}, 32'h0);
    check("t6_async_avail", 32'(avail), 32'h0);
    step(3);
    RST_N = 1'b1;
    step(2);
    send4(32'h0000002A);
    step(3);
    do_read(50, w, rq, vc, bl);
    check("t6_word", w, 32'h0000002A);

    step(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #(98000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

endmodule
